kws_frame_loader: RTL and testbench

// - Streams KWS input feature words (32b valid/ready) into the SMS1 data SRAM as ping-pong frames.
// - Two frame buffers: buf0 at BUF0_BASE, buf1 at BUF1_BASE; CPU consumes a frame while the other fills.
// - Replaces the simulation-only backdoor preload of input sets; irq per completed frame.

---
 rtl/kws_loader_pkg.sv | 24 ++
 rtl/kws_loader_wr_slot.sv | 37 +++
 rtl/kws_frame_loader.sv | 174 +++++++++++++++++
 tb/tb_kws_frame_loader.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kws_loader_pkg.sv
// Shared types and defaults for the KWS frame loader.
package kws_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT_BUF,
        FILL,
        DRAIN
    } state_t;

    localparam int unsigned FRAME_WORDS_DEF = 1168;
    localparam int unsigned AW_DEF          = 14;
    localparam int unsigned BUF0_BASE_DEF   = 32'h0000;
    localparam int unsigned BUF1_BASE_DEF   = 32'h0490;

    // Bits needed to count 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned IDX_W = cnt_width(FRAME_WORDS_DEF);

endpackage

// File: rtl/kws_loader_wr_slot.sv
// One-entry holding register between the feature stream and the SRAM write port.
module kws_loader_wr_slot
    import kws_loader_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_req,
    input  logic          out_gnt,
    output logic [DW-1:0] out_data
);

    logic          full;
    logic [DW-1:0] data_q;

    assign in_ready = !full || out_gnt;
    assign out_req  = full;
    assign out_data = data_q;

    // Load on accept (may refill in the same cycle the held word is granted), empty on grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full   <= 1'b0;
            data_q <= '0;
        end else if (in_valid && in_ready) begin
            full   <= 1'b1;
            data_q <= in_data;
        end else if (full && out_gnt) begin
            full   <= 1'b0;
        end
    end

endmodule

// File: rtl/kws_frame_loader.sv
// KWS input feature stream -> SMS1 data SRAM ping-pong frame loader.
// Optional feature: define KWS_LOADER_CKSUM_EN to add the frame_sum output.
module kws_frame_loader
    import kws_loader_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int unsigned AW          = AW_DEF,
    parameter int unsigned BUF0_BASE   = BUF0_BASE_DEF,
    parameter int unsigned BUF1_BASE   = BUF1_BASE_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cont,
    input  logic          abort,
    input  logic [1:0]    buf_release,
    input  logic          irq_clr,
    input  logic          s_valid,
    input  logic [31:0]   s_data,
    input  logic          s_last,
    output logic          s_ready,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic [1:0]    buf_full,
    output logic          last_buf,
    output logic          frame_done,
    output logic          irq,
    output logic          err
`ifdef KWS_LOADER_CKSUM_EN
    ,
    output logic [31:0]   frame_sum
`endif
);

    localparam int unsigned CW = cnt_width(FRAME_WORDS);

    if ((BUF0_BASE + FRAME_WORDS > (1 << AW)) || (BUF1_BASE + FRAME_WORDS > (1 << AW))) begin : g_cfg_err
        $error("kws_frame_loader: frame buffer exceeds SRAM address space");
    end

    state_t        state;
    logic          wr_buf;
    logic [CW-1:0] idx;
    logic [CW-1:0] acc_cnt;
    logic          slot_ready;
    logic          slot_full;
    logic          accept;
    logic          wr_gnt;
    logic          last_gnt;
    logic [AW-1:0] base_sel;

    assign s_ready  = (state == FILL) && !abort && (acc_cnt < CW'(FRAME_WORDS)) && slot_ready;
    assign accept   = s_valid && s_ready;
    assign wr_gnt   = slot_full && mem_gnt;
    assign last_gnt = wr_gnt && (state == FILL) && (idx == CW'(FRAME_WORDS - 1));
    assign base_sel = wr_buf ? AW'(BUF1_BASE) : AW'(BUF0_BASE);
    assign mem_addr = base_sel + AW'(idx);
    assign mem_req  = slot_full;

    kws_loader_wr_slot #(.DW(32)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .in_valid (accept),
        .in_ready (slot_ready),
        .in_data  (s_data),
        .out_req  (slot_full),
        .out_gnt  (mem_gnt),
        .out_data (mem_wdata)
    );

    // Frame sequencing, buffer ownership and status flags.
    // Later non-blocking writes in this block take priority, which gives
    // set-over-release on buf_full and set-over-clear on irq/err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            wr_buf     <= 1'b0;
            last_buf   <= 1'b0;
            idx        <= '0;
            acc_cnt    <= '0;
            buf_full   <= '0;
            frame_done <= 1'b0;
            irq        <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            buf_full   <= buf_full & ~buf_release;
            if (irq_clr) begin
                irq <= 1'b0;
                err <= 1'b0;
            end
            if (accept) begin
                acc_cnt <= acc_cnt + 1'b1;
                if (s_last != (acc_cnt == CW'(FRAME_WORDS - 1)))
                    err <= 1'b1;
            end
            if (wr_gnt)
                idx <= idx + 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= CHECK;
                        busy  <= 1'b1;
                    end
                end
                CHECK: begin
                    if (abort)
                        state <= DRAIN;
                    else if (!buf_full[wr_buf])
                        state <= FILL;
                    else
                        state <= WAIT_BUF;
                end
                WAIT_BUF: begin
                    if (abort)
                        state <= DRAIN;
                    else if (!buf_full[wr_buf] || buf_release[wr_buf])
                        state <= FILL;
                end
                FILL: begin
                    if (last_gnt) begin
                        buf_full[wr_buf] <= 1'b1;
                        last_buf         <= wr_buf;
                        frame_done       <= 1'b1;
                        irq              <= 1'b1;
                        wr_buf           <= ~wr_buf;
                        idx              <= '0;
                        acc_cnt          <= '0;
                        state            <= (cont && !abort) ? CHECK : IDLE;
                        busy             <= cont && !abort;
                    end else if (abort) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!slot_full || mem_gnt) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        idx     <= '0;
                        acc_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef KWS_LOADER_CKSUM_EN
    logic [31:0] sum_run;

    // Running mod-2^32 sum of accepted words, published when a frame completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_run   <= '0;
            frame_sum <= '0;
        end else if (last_gnt) begin
            frame_sum <= sum_run;
            sum_run   <= '0;
        end else if ((state == IDLE && start) || (state != IDLE && abort)) begin
            sum_run   <= '0;
        end else if (accept) begin
            sum_run   <= sum_run + s_data;
        end
    end
`endif

endmodule

// File: tb/tb_kws_frame_loader.sv
// Self-checking bench for kws_frame_loader (add KWS_LOADER_CKSUM_EN to cover frame_sum).
module tb_kws_frame_loader;

    localparam int FW = 1168;
    localparam int B0 = 'h000;
    localparam int B1 = 'h490;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cont;
    logic        abort;
    logic [1:0]  buf_release;
    logic        irq_clr;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic        mem_req;
    logic        mem_gnt;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic [1:0]  buf_full;
    logic        last_buf;
    logic        frame_done;
    logic        irq;
    logic        err;
`ifdef KWS_LOADER_CKSUM_EN
    logic [31:0] frame_sum;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: accepted word k of a run belongs to frame k/FW, offset k%FW,
    // frames alternate buf0/buf1, and writes must reach SRAM in acceptance order.
    int          m_cnt;
    int          m_abuf;
    int          m_wbuf;
    int          m_wcnt;
    int          m_frames;
    int          m_done_seen;
    logic [1:0]  m_full;
    logic        m_last;
    logic [31:0] m_sum;
    logic [31:0] m_frame_sum;
    int unsigned exp_a[$];
    logic [31:0] exp_d[$];

    kws_frame_loader #(
        .FRAME_WORDS (FW),
        .AW          (14),
        .BUF0_BASE   (B0),
        .BUF1_BASE   (B1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cont        (cont),
        .abort       (abort),
        .buf_release (buf_release),
        .irq_clr     (irq_clr),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .mem_req     (mem_req),
        .mem_gnt     (mem_gnt),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .buf_full    (buf_full),
        .last_buf    (last_buf),
        .frame_done  (frame_done),
        .irq         (irq),
        .err         (err)
`ifdef KWS_LOADER_CKSUM_EN
        ,
        .frame_sum   (frame_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

    function automatic int unsigned base_of(input int b);
        return (b != 0) ? B1 : B0;
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_abuf = 0; m_wbuf = 0; m_wcnt = 0; m_frames = 0; m_done_seen = 0;
        m_full = 2'b00; m_last = 1'b0; m_sum = '0; m_frame_sum = '0;
        exp_a.delete(); exp_d.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; buf_release = 2'b00;
        irq_clr = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; mem_gnt = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Streams words until `frames` more frames have been written, scoreboarding every write.
    // gnt_mode: 0 always granted, 1 toggling, 2 random.
    task automatic pump(input int frames, input int gnt_mode, input int err_at, input bit ones);
        int          cyc;
        int          target;
        bit          held;
        bit          acc;
        logic [13:0] h_addr;
        logic [31:0] h_data;
        int unsigned ea;
        logic [31:0] ed;
        cyc = 0; held = 0; target = m_frames + frames;
        while (m_frames < target && cyc < frames * 6000) begin
            case (gnt_mode)
                0:       mem_gnt = 1'b1;
                1:       mem_gnt = (cyc % 2 == 0);
                default: mem_gnt = 1'($urandom_range(0, 1));
            endcase
            if (!s_valid && $urandom_range(0, 3) != 0) begin
                s_valid = 1'b1;
                s_data  = ones ? 32'hFFFF_FFFF : $urandom;
                s_last  = (m_cnt == FW - 1) || (m_cnt == err_at);
            end
            acc = 0;
            @(negedge clk);
            if (frame_done === 1'b1) m_done_seen++;
            if (held) begin
                n_total++;
                if (mem_req !== 1'b1 || mem_addr !== h_addr || mem_wdata !== h_data)
                    $display("FAIL hold_stable: req=%b addr=%h data=%h, required req=1 addr=%h data=%h",
                             mem_req, mem_addr, mem_wdata, h_addr, h_data);
                else
                    n_pass++;
            end
            held = 0;
            if (mem_req === 1'b1 && mem_gnt) begin
                n_total++;
                if (exp_a.size() == 0) begin
                    $display("FAIL write_unexpected: addr=%h data=%h, no word outstanding", mem_addr, mem_wdata);
                end else begin
                    ea = exp_a.pop_front();
                    ed = exp_d.pop_front();
                    if (mem_addr !== 14'(ea) || mem_wdata !== ed)
                        $display("FAIL write: addr=%h data=%h, required addr=%h data=%h", mem_addr, mem_wdata, 14'(ea), ed);
                    else
                        n_pass++;
                end
                m_wcnt++;
                if (m_wcnt == FW) begin
                    m_wcnt = 0; m_full[m_wbuf] = 1'b1; m_last = 1'(m_wbuf); m_wbuf ^= 1; m_frames++;
                end
            end else if (mem_req === 1'b1) begin
                held = 1; h_addr = mem_addr; h_data = mem_wdata;
            end
            if (s_valid && s_ready === 1'b1) begin
                acc = 1;
                exp_a.push_back(base_of(m_abuf) + m_cnt);
                exp_d.push_back(s_data);
                m_sum += s_data;
                m_cnt++;
                if (m_cnt == FW) begin
                    m_cnt = 0; m_abuf ^= 1; m_frame_sum = m_sum; m_sum = '0;
                end
            end
            @(posedge clk); #1;
            if (acc) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            cyc++;
        end
        if (m_frames < target) begin
            n_total++;
            $display("FAIL pump_timeout: frames written=%0d, required %0d", m_frames, target);
        end
        s_valid = 1'b0; s_last = 1'b0; mem_gnt = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (frame_done === 1'b1) m_done_seen++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_total++;
        if ({s_ready, mem_req, busy, buf_full, last_buf, frame_done, irq, err} !== 9'b0)
            $display("FAIL reset_flags: got %b, required 000000000",
                     {s_ready, mem_req, busy, buf_full, last_buf, frame_done, irq, err});
        else n_pass++;
        n_total++;
        if (mem_addr !== 14'h0 || mem_wdata !== 32'h0)
            $display("FAIL reset_mem: addr=%h data=%h, required 0/0", mem_addr, mem_wdata);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame();
        do_reset();
        cont = 1'b0;
        pulse_start();
        pump(1, 0, -1, 1'b0);
        n_total++;
        if ({busy, buf_full, last_buf, irq, err} !== 6'b0_01_0_1_0)
            $display("FAIL single_status: busy,buf_full,last_buf,irq,err=%b, required 001010",
                     {busy, buf_full, last_buf, irq, err});
        else n_pass++;
        n_total++;
        if (m_done_seen != 1 || exp_a.size() != 0)
            $display("FAIL single_done: frame_done pulses=%0d pending=%0d, required 1/0", m_done_seen, exp_a.size());
        else n_pass++;
`ifdef KWS_LOADER_CKSUM_EN
        n_total++;
        if (frame_sum !== m_frame_sum)
            $display("FAIL single_sum: got %h, required %h", frame_sum, m_frame_sum);
        else n_pass++;
`endif
    endtask

    task automatic test_cont_and_release();
        int rdy_seen;
        int req_seen;
        do_reset();
        cont = 1'b1;
        pulse_start();
        pump(2, 0, -1, 1'b0);
        n_total++;
        if ({buf_full, last_buf, busy} !== 4'b11_1_1 || m_done_seen != 2)
            $display("FAIL cont_status: buf_full,last_buf,busy=%b pulses=%0d, required 1111/2",
                     {buf_full, last_buf, busy}, m_done_seen);
        else n_pass++;
        // Both buffers owned by the CPU: the loader must stall with the stream blocked.
        rdy_seen = 0; req_seen = 0;
        s_valid = 1'b1; s_data = $urandom;
        repeat (8) begin
            @(negedge clk);
            if (s_ready !== 1'b0) rdy_seen++;
            if (mem_req !== 1'b0) req_seen++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        n_total++;
        if (rdy_seen != 0 || req_seen != 0 || busy !== 1'b1)
            $display("FAIL stall: s_ready cycles=%0d mem_req cycles=%0d busy=%b, required 0/0/1", rdy_seen, req_seen, busy);
        else n_pass++;
        buf_release = 2'b01; m_full[0] = 1'b0;
        @(posedge clk); #1;
        buf_release = 2'b00;
        cont = 1'b0;
        @(negedge clk);
        n_total++;
        if (s_ready !== 1'b1 || buf_full !== 2'b10)
            $display("FAIL release: s_ready=%b buf_full=%b, required 1/10", s_ready, buf_full);
        else n_pass++;
        @(posedge clk); #1;
        pump(1, 0, -1, 1'b0);
        n_total++;
        if ({buf_full, last_buf, busy} !== {m_full, m_last, 1'b0} || m_done_seen != 3 || exp_a.size() != 0)
            $display("FAIL third_frame: buf_full,last_buf,busy=%b pulses=%0d, required %b/3",
                     {buf_full, last_buf, busy}, m_done_seen, {m_full, m_last, 1'b0});
        else n_pass++;
    endtask

    task automatic test_gnt_toggle();
        do_reset();
        cont = 1'b1;
        pulse_start();
        pump(1, 1, -1, 1'b0);
        pump(1, 2, -1, 1'b0);
        n_total++;
        if ({buf_full, last_buf} !== 3'b11_1 || m_done_seen != 2 || exp_a.size() != 0)
            $display("FAIL toggle_status: buf_full,last_buf=%b pulses=%0d pending=%0d, required 111/2/0",
                     {buf_full, last_buf}, m_done_seen, exp_a.size());
        else n_pass++;
    endtask

    task automatic test_abort();
        bit          got;
        logic [31:0] w;
        do_reset();
        cont = 1'b0;
        pulse_start();
        w = $urandom;
        s_valid = 1'b1; s_data = w; mem_gnt = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (s_ready === 1'b1) got = 1;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        n_total++;
        if (!got) $display("FAIL abort_accept: word not accepted within 10 cycles, required accept");
        else n_pass++;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_total++;
            if ({mem_req, s_ready, busy} !== 3'b101 || mem_addr !== 14'(B0) || mem_wdata !== w)
                $display("FAIL abort_hold: req,s_ready,busy=%b addr=%h data=%h, required 101 addr=%h data=%h",
                         {mem_req, s_ready, busy}, mem_addr, mem_wdata, 14'(B0), w);
            else n_pass++;
            @(posedge clk); #1;
        end
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy, mem_req, buf_full, frame_done, irq} !== 6'b0)
            $display("FAIL abort_end: busy,req,buf_full,frame_done,irq=%b, required 000000",
                     {busy, mem_req, buf_full, frame_done, irq});
        else n_pass++;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL abort_idle: busy=%b, required 0", busy);
        else n_pass++;
        @(posedge clk); #1;
        // A fresh frame after abort restarts at offset 0 of the same buffer.
        pulse_start();
        pump(1, 2, -1, 1'b0);
        n_total++;
        if ({buf_full, last_buf} !== 3'b01_0 || m_done_seen != 1)
            $display("FAIL abort_restart: buf_full,last_buf=%b pulses=%0d, required 010/1", {buf_full, last_buf}, m_done_seen);
        else n_pass++;
    endtask

    task automatic test_slast_err();
        do_reset();
        cont = 1'b0;
        pulse_start();
        pump(1, 0, 100, 1'b0);
        n_total++;
        if ({err, irq} !== 2'b11 || m_done_seen != 1 || exp_a.size() != 0)
            $display("FAIL slast_err: err,irq=%b pulses=%0d pending=%0d, required 11/1/0",
                     {err, irq}, m_done_seen, exp_a.size());
        else n_pass++;
        irq_clr = 1'b1;
        @(posedge clk); #1;
        irq_clr = 1'b0;
        @(negedge clk);
        n_total++;
        if ({err, irq} !== 2'b00)
            $display("FAIL irq_clr: err,irq=%b, required 00", {err, irq});
        else n_pass++;
        @(posedge clk); #1;
    endtask

`ifdef KWS_LOADER_CKSUM_EN
    task automatic test_cksum();
        do_reset();
        cont = 1'b0;
        pulse_start();
        pump(1, 2, -1, 1'b1);
        n_total++;
        if (frame_sum !== 32'hFFFF_FB70)
            $display("FAIL cksum_ones: got %h, required FFFFFB70", frame_sum);
        else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; buf_release = 2'b00;
        irq_clr = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; mem_gnt = 1'b0;
        test_reset();
        test_single_frame();
        test_cont_and_release();
        test_gnt_toggle();
        test_abort();
        test_slast_err();
`ifdef KWS_LOADER_CKSUM_EN
        test_cksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
